// File: rtl/grf_wb_sink_pkg.sv
// Shared constants for the writeback-side general register file.
package grf_wb_sink_pkg;

    localparam logic [4:0]  GPR_ZERO = 5'd0;
    localparam logic [4:0]  GPR_RA   = 5'd31;
    localparam int unsigned GPR_NUM  = 32;

endpackage

// File: rtl/grf_read_port.sv
// One combinational GPR read port with same-cycle writeback bypass.
module grf_read_port
    import grf_wb_sink_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] word,
    input  logic              commit,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = word;
        // r0 wins over the bypass so a dropped write can never leak through
        if (addr == ADDR_W'(GPR_ZERO)) begin
            data = '0;
        end else if (commit && (wb_addr == addr)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/grf_wb_sink.sv
// GPR array at the writeback end: commits W-stage writes, serves two bypassed D-stage read
// ports and keeps a registered commit trace plus a commit counter.
module grf_wb_sink
    import grf_wb_sink_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              trace_valid,
    output logic [DATA_W-1:0] trace_pc,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic [CNT_W-1:0]  commit_cnt
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic              commit;
    logic [DATA_W-1:0] gpr [1:NumRegs-1];
    logic [DATA_W-1:0] rs_word;
    logic [DATA_W-1:0] rt_word;

    // Short-circuit keeps an X address harmless while wb_we is low
    assign commit = wb_we && (wb_addr != ADDR_W'(GPR_ZERO));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NumRegs; i++) begin
                gpr[i] <= '0;
            end
        end else if (commit) begin
            gpr[wb_addr] <= wb_data;
        end
    end

    // r0 has no storage; the read port forces it to zero
    always_comb begin
        rs_word = '0;
        rt_word = '0;
        if (rs_addr != ADDR_W'(GPR_ZERO)) rs_word = gpr[rs_addr];
        if (rt_addr != ADDR_W'(GPR_ZERO)) rt_word = gpr[rt_addr];
    end

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs_port (
        .addr    (rs_addr),
        .word    (rs_word),
        .commit  (commit),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .data    (rs_data)
    );

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rt_port (
        .addr    (rt_addr),
        .word    (rt_word),
        .commit  (commit),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .data    (rt_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                trace_pc   <= wb_pc;
                trace_addr <= wb_addr;
                trace_data <= wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_cnt <= '0;
        end else if (commit) begin
            commit_cnt <= commit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_grf_wb_sink.sv
// Directed and model-checked stimulus for grf_wb_sink; a 2-bit counter copy covers wraparound.
module tb_grf_wb_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data, rt_data, trace_pc, trace_data, commit_cnt;
    logic [4:0]  trace_addr;
    logic        trace_valid;

    logic [31:0] s_rs_data, s_rt_data, s_trace_pc, s_trace_data;
    logic [4:0]  s_trace_addr;
    logic        s_trace_valid;
    logic [1:0]  s_commit_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_gpr [0:31];
    logic [31:0] m_cnt;
    logic        m_tv;
    logic [31:0] m_tpc, m_tdata;
    logic [4:0]  m_taddr;

    always #5 clk = ~clk;

    grf_wb_sink dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_pc       (wb_pc),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .commit_cnt  (commit_cnt)
    );

    grf_wb_sink #(
        .CNT_W (2)
    ) dut_small (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_pc       (wb_pc),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (s_rs_data),
        .rt_data     (s_rt_data),
        .trace_valid (s_trace_valid),
        .trace_pc    (s_trace_pc),
        .trace_addr  (s_trace_addr),
        .trace_data  (s_trace_data),
        .commit_cnt  (s_commit_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
        wb_pc   = pc;
        rs_addr = rs;
        rt_addr = rt;
        #1;
    endtask

    // Advance one clock; the model tracks the same commit rule to score the random phase.
    task automatic tick();
        logic c;
        c = wb_we && (wb_addr != 5'd0);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = '0;
            m_cnt = '0; m_tv = 1'b0; m_tpc = '0; m_taddr = '0; m_tdata = '0;
        end else begin
            m_tv = c;
            if (c) begin
                m_gpr[wb_addr] = wb_data;
                m_cnt          = m_cnt + 1;
                m_tpc          = wb_pc;
                m_taddr        = wb_addr;
                m_tdata        = wb_data;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (wb_we && wb_addr != 5'd0 && wb_addr == a) return wb_data;
        return m_gpr[a];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_cnt = '0; m_tv = 1'b0; m_tpc = '0; m_taddr = '0; m_tdata = '0;
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;

        // 1: cleared array, idle trace, zero count
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
            check_eq($sformatf("rst_rs%0d", i), rs_data, 32'h0);
            check_eq($sformatf("rst_rt%0d", 31 - i), rt_data, 32'h0);
        end
        check_eq("rst_tv", {31'b0, trace_valid}, 32'h0);
        check_eq("rst_cnt", commit_cnt, 32'h0);

        // 2: bypass then array read, trace of the commit
        drive(1'b1, 5'd8, 32'h1234_5678, 32'h0000_3000, 5'd8, 5'd0);
        check_eq("byp_rs8", rs_data, 32'h1234_5678);
        check_eq("byp_rt0", rt_data, 32'h0);
        tick();
        drive(1'b0, 5'd8, 32'hDEAD_BEEF, 32'h0, 5'd8, 5'd8);
        check_eq("arr_rs8", rs_data, 32'h1234_5678);
        check_eq("arr_rt8", rt_data, 32'h1234_5678);
        check_eq("tr_valid", {31'b0, trace_valid}, 32'h1);
        check_eq("tr_pc", trace_pc, 32'h0000_3000);
        check_eq("tr_addr", {27'b0, trace_addr}, 32'd8);
        check_eq("tr_data", trace_data, 32'h1234_5678);
        check_eq("cnt_1", commit_cnt, 32'd1);

        // 3: write to r0 is dropped everywhere
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004, 5'd0, 5'd0);
        check_eq("r0_rs", rs_data, 32'h0);
        check_eq("r0_rt", rt_data, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd8);
        check_eq("r0_tv", {31'b0, trace_valid}, 32'h0);
        check_eq("r0_cnt", commit_cnt, 32'd1);
        check_eq("r0_tpc_hold", trace_pc, 32'h0000_3000);
        check_eq("r0_r8_kept", rt_data, 32'h1234_5678);

        // 4: jal link, both ports bypass to r31
        drive(1'b1, 5'd31, 32'h0000_300C, 32'h0000_3008, 5'd31, 5'd31);
        check_eq("jal_rs", rs_data, 32'h0000_300C);
        check_eq("jal_rt", rt_data, 32'h0000_300C);
        tick();
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd8);
        check_eq("jal_arr", rs_data, 32'h0000_300C);
        check_eq("jal_cnt", commit_cnt, 32'd2);
        check_eq("jal_taddr", {27'b0, trace_addr}, 32'd31);

        // 5: reset beats a simultaneous commit
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'd7, 32'h0000_3010, 5'd5, 5'd31);
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);
        check_eq("rstw_r5", rs_data, 32'h0);
        check_eq("rstw_r31", rt_data, 32'h0);
        check_eq("rstw_tv", {31'b0, trace_valid}, 32'h0);
        check_eq("rstw_cnt", commit_cnt, 32'h0);
        check_eq("rstw_tpc", trace_pc, 32'h0);

        // 6: counter wrap on the 2-bit copy (3 -> 0 on the fourth commit)
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(i * 16'h1111), 32'(32'h4000 + 4 * i), 5'd0, 5'd0);
            tick();
            if (i == 3) check_eq("wrap_3", {30'b0, s_commit_cnt}, 32'd3);
        end
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd2, 5'd4);
        check_eq("wrap_0", {30'b0, s_commit_cnt}, 32'd0);
        check_eq("wrap_main", commit_cnt, 32'd4);
        check_eq("wr_r2", rs_data, 32'h0000_2222);
        check_eq("wr_r4", rt_data, 32'h0000_4444);

        // Random traffic scored against the array model with the bypass rule
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [4:0]  a, rs, rt;
            we = ($urandom_range(0, 3) != 0);
            a  = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            drive(we, a, $urandom, $urandom, rs, rt);
            check_eq($sformatf("rnd%0d_rs", n), rs_data, exp_read(rs));
            check_eq($sformatf("rnd%0d_rt", n), rt_data, exp_read(rt));
            tick();
            check_eq($sformatf("rnd%0d_tv", n), {31'b0, trace_valid}, {31'b0, m_tv});
            check_eq($sformatf("rnd%0d_tpc", n), trace_pc, m_tpc);
            check_eq($sformatf("rnd%0d_tdata", n), trace_data, m_tdata);
            check_eq($sformatf("rnd%0d_taddr", n), {27'b0, trace_addr}, {27'b0, m_taddr});
            check_eq($sformatf("rnd%0d_cnt", n), commit_cnt, m_cnt);
        end
        check_eq("rnd_small_cnt", {30'b0, s_commit_cnt}, {30'b0, m_cnt[1:0]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
